// File: rtl/agu_config_queue.sv
// AGU configuration queue: buffers per-pass configurations with derived limits
// and issues one start_fc/start_conv pulse per entry as the AGU finishes each pass.
module agu_config_queue #(
    parameter int IDX_W  = 8,
    parameter int TRIP_W = 8,
    parameter int LIM_W  = 6,
    parameter int KSIZE  = 3,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [IDX_W-1:0]  idx_cnt,
    input  logic [TRIP_W-1:0] trip_cnt,
    input  logic              is_new,
    input  logic [3:0]        pad_code,
    input  logic              cut_y,
    input  logic              agu_done,
    output logic              cfg_ready,
    output logic              busy,
    output logic              cfg_err,
    output logic [1:0]        conf_mode,
    output logic [IDX_W-1:0]  conf_idx_cnt,
    output logic [TRIP_W-1:0] conf_trip_cnt,
    output logic              conf_is_new,
    output logic              conf_pad_u,
    output logic              conf_pad_l,
    output logic [LIM_W-1:0]  conf_lim_r,
    output logic [LIM_W-1:0]  conf_lim_d,
    output logic [LIM_W-1:0]  conf_row_cnt,
    output logic              start_fc,
    output logic              start_conv
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_C = DEPTH[AW:0];
    localparam logic [LIM_W-1:0] KSIZE_C = LIM_W'(KSIZE);
    localparam logic [LIM_W-1:0] KOFF_C  = LIM_W'(KSIZE - 2);

    typedef struct packed {
        logic [1:0]        mode;
        logic [IDX_W-1:0]  idx_cnt;
        logic [TRIP_W-1:0] trip_cnt;
        logic              is_new;
        logic              pad_u;
        logic              pad_l;
        logic [LIM_W-1:0]  lim_r;
        logic [LIM_W-1:0]  lim_d;
        logic [LIM_W-1:0]  row_cnt;
    } entry_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    entry_t            mem_q [DEPTH];
    entry_t            push_entry;
    entry_t            conf_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    logic [TRIP_W:0]   trip_half;
    state_t            state_q;
    logic              start_fc_q, start_conv_q;
    logic              cfg_err_q;
    logic              pulse_q;
    logic              push, pop;
    logic              fifo_empty;

    // Derived fields are folded into the entry at push time so the issue path is a plain load.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        push_entry          = '0;
        trip_half           = ({1'b0, trip_cnt} + 1'b1) >> 1;
        push_entry.mode     = mode;
        push_entry.idx_cnt  = idx_cnt;
        push_entry.trip_cnt = trip_cnt;
        push_entry.is_new   = is_new;
        push_entry.pad_u    = pad_code[0];
        push_entry.pad_l    = pad_code[2];
        push_entry.lim_d    = KSIZE_C - LIM_W'(pad_code[0]) - LIM_W'(pad_code[1])
                              - LIM_W'(cut_y);
        push_entry.lim_r    = LIM_W'(trip_cnt) + KOFF_C - LIM_W'(pad_code[2])
                              - LIM_W'(pad_code[3]);
        push_entry.row_cnt  = LIM_W'(trip_half) - LIM_W'(1);
    end

    assign fifo_empty = (count_q == '0);
    assign cfg_ready  = (count_q < DEPTH_C);
    assign push       = start && cfg_ready;
    assign pulse_q    = start_fc_q || start_conv_q;
    // agu_done is only meaningful in RUN and never in the issue-pulse cycle.
    assign pop        = !fifo_empty &&
                        ((state_q == IDLE) || (agu_done && !pulse_q));

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage array is not reset; occupancy is tracked by count/pointers only.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (start && !cfg_ready) begin
                cfg_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            conf_q         <= '0;
            conf_q.is_new  <= 1'b1;
            start_fc_q     <= 1'b0;
            start_conv_q   <= 1'b0;
        end else begin
            start_fc_q   <= 1'b0;
            start_conv_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (agu_done && !pulse_q && fifo_empty) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (pop) begin
                conf_q       <= mem_q[rd_ptr_q];
                start_fc_q   <= mem_q[rd_ptr_q].mode[0];
                start_conv_q <= !mem_q[rd_ptr_q].mode[0];
            end
        end
    end

    assign busy          = (state_q == RUN) || !fifo_empty;
    assign cfg_err       = cfg_err_q;
    assign conf_mode     = conf_q.mode;
    assign conf_idx_cnt  = conf_q.idx_cnt;
    assign conf_trip_cnt = conf_q.trip_cnt;
    assign conf_is_new   = conf_q.is_new;
    assign conf_pad_u    = conf_q.pad_u;
    assign conf_pad_l    = conf_q.pad_l;
    assign conf_lim_r    = conf_q.lim_r;
    assign conf_lim_d    = conf_q.lim_d;
    assign conf_row_cnt  = conf_q.row_cnt;
    assign start_fc      = start_fc_q;
    assign start_conv    = start_conv_q;

endmodule

// File: doc/agu_config_queue.md
Name: agu_config_queue

Overview:
- Parametrised next-generation AGU configuration stage for the PE.
- Accepts per-pass AGU configuration on a start strobe and buffers it in a DEPTH-entry FIFO. Each entry is issued to the address generator only after the previous pass reports completion.
- Issuing an entry means loading the conf_* registers and emitting exactly one start_fc or start_conv pulse.
- Generalises the fixed-width, 3x3, single-entry config latch to configurable widths and kernel size. Adds queueing, ready/busy/overflow status and correct FC/conv mode decode.

Parameters:
IDX_W, 8, width of idx_cnt
TRIP_W, 8, width of trip_cnt
LIM_W, 6, width of conf_lim_r, conf_lim_d, conf_row_cnt
KSIZE, 3, kernel size used in limit arithmetic (>=2)
DEPTH, 2, FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  push config this cycle
mode  in  2  pass mode; mode[0]=1 is FC, else conv
idx_cnt  in  IDX_W  number of indices
trip_cnt  in  TRIP_W  cycles per AGU trip
is_new  in  1  new-accumulation flag
pad_code  in  4  padding {R,L,D,U}
cut_y  in  1  trim last kernel row
agu_done  in  1  one-cycle pulse from AGU: current pass finished
cfg_ready  out  1  FIFO can accept a push
busy  out  1  pass running or FIFO non-empty
cfg_err  out  1  sticky: push attempted while not ready
conf_mode  out  2  active mode
conf_idx_cnt  out  IDX_W  active idx count
conf_trip_cnt  out  TRIP_W  active trip count
conf_is_new  out  1  active is_new
conf_pad_u  out  1  pad_code[0] of active entry
conf_pad_l  out  1  pad_code[2] of active entry
conf_lim_r  out  LIM_W  column limit
conf_lim_d  out  LIM_W  row limit
conf_row_cnt  out  LIM_W  row-pair count
start_fc  out  1  one-cycle issue pulse, FC pass
start_conv  out  1  one-cycle issue pulse, conv pass

Behaviour:
- Clock is clk. rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset values:
  - conf_is_new=1; all other conf_*=0.
  - start_fc=0, start_conv=0, cfg_err=0, busy=0, cfg_ready=1.
  - FIFO empty; FSM in IDLE.
- Reset asserted mid-pass discards the active pass and all queued entries. No start pulse appears in the cycle after reset.
- Derived fields are computed at push time and stored in the FIFO entry. All arithmetic is unsigned and truncated modulo 2^LIM_W:
  - lim_d = KSIZE - pad_code[0] - pad_code[1] - cut_y
  - lim_r = trip_cnt + (KSIZE-2) - pad_code[2] - pad_code[3]
  - row_cnt = ceil(trip_cnt/2) - 1. trip_cnt=0 gives all-ones.
- Push:
  - cfg_ready = (count < DEPTH), combinational from the occupancy count.
  - A start with cfg_ready=1 writes one entry.
  - A start with cfg_ready=0 is dropped: FIFO unchanged, cfg_err set until rst.
- FSM has two states, IDLE and RUN.
  - IDLE: when the FIFO is non-empty, pop the head. On that edge, load all conf_* and set exactly one pulse register: start_fc if mode[0]=1, else start_conv. Go to RUN.
  - RUN: agu_done is ignored in the cycle the start pulse is high. Otherwise, agu_done=1 with a non-empty FIFO pops the next entry (back-to-back issue) and stays in RUN. agu_done=1 with an empty FIFO goes to IDLE.
  - agu_done in IDLE is ignored.
- Pulses are exactly one cycle wide.
- conf_* hold their values until the next pop. They do not change on agu_done alone.
- Latency: a push into an empty FIFO while in IDLE at edge t gives conf_* valid and the start pulse high in the cycle after edge t+1.
- Push and pop on the same edge leave count unchanged. A push into a full FIFO on the pop edge is still dropped, because cfg_ready was 0 that cycle.
- busy = (state==RUN) || (count!=0).

Test Plan:
- KSIZE=3, mode=00, pad=0000, cut_y=0, trip=8, idx=5, push while IDLE -> two cycles later start_conv=1 for one cycle, start_fc=0; lim_r=9, lim_d=3, row_cnt=3, idx=5.
- mode=11, pad=1111, cut_y=1, trip=7 -> start_fc pulse only; lim_d=0, lim_r=6, row_cnt=3, pad_u=1, pad_l=1. Repeat with mode=01 -> start_fc; mode=10 -> start_conv.
- DEPTH=2, AGU held busy (no agu_done), push 3 configs after the first is issued:
  - after two queued, cfg_ready=0; third push dropped and cfg_err=1;
  - successive agu_done pulses issue queued entries back-to-back, one cycle after each agu_done;
  - busy drops after the last agu_done.
- agu_done asserted in the same cycle as the start pulse -> ignored; pass continues until a later agu_done.
- trip=0, pad=0000 -> row_cnt=63, lim_r=1 (LIM_W=6). Simultaneous push and pop with count=1 -> count stays 1.
- rst asserted in RUN with 1 entry queued -> next cycle all outputs at reset values, no further start pulses without new pushes.
